nios_led_out: RTL and testbench



---
 rtl/nios_led_out.sv | 164 ++++++++++++++++
 tb/tb_nios_led_out.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_led_out.sv
// +--------------------------------------------------------------------------+
// | nios_led_out : Avalon-MM output port with set/clear and one-shot pulse    |
// | Optional pulse engine enabled by NIOS_LED_OUT_PULSE_EN.  Revision: 1.0    |
// +--------------------------------------------------------------------------+
`default_nettype none

module nios_led_out #(
  parameter int               WIDTH       = 8,
  parameter int               PULSE_W     = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  output logic [WIDTH-1:0] out_port
);

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] out_wr;
  logic [WIDTH-1:0] out_d, out_q;
  logic [31:0]      readdata_d, readdata_q;
  logic             unused_ok;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_ok = ^writedata;

  // Output value after any DATA/OUTSET/OUTCLR write; the pulse toggle is applied on top.
  always_comb begin
    out_wr = out_q;
    if (wr) begin
      case (address)
        3'd0:    out_wr = wd;
        3'd4:    out_wr = out_q | wd;
        3'd5:    out_wr = out_q & ~wd;
        default: out_wr = out_q;
      endcase
    end
  end

`ifdef NIOS_LED_OUT_PULSE_EN
  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t             state_d, state_q;
  logic [PULSE_W-1:0] len_d, len_q;
  logic [PULSE_W-1:0] cnt_d, cnt_q;
  logic [WIDTH-1:0]   mask_d, mask_q;
  logic               irq_mask_d, irq_mask_q;
  logic               done_d, done_q;
  logic               overrun_d, overrun_q;
  logic               pulse_wr;
  logic               restore;

  assign pulse_wr = wr && (address == 3'd6);
  assign restore  = (state_q == ACTIVE) && (cnt_q == PULSE_W'(1));

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    irq_mask_d = irq_mask_q;
    done_d     = done_q;
    overrun_d  = overrun_q;
    out_d      = out_wr;

    if (wr && (address == 3'd1)) len_d      = writedata[PULSE_W-1:0];
    if (wr && (address == 3'd2)) irq_mask_d = writedata[0];
    if (wr && (address == 3'd3)) begin
      done_d    = 1'b0;
      overrun_d = 1'b0;
    end

    // Set conditions below take priority over the STATUS write clear above.
    case (state_q)
      IDLE: begin
        if (pulse_wr && (wd != '0)) begin
          out_d   = out_wr ^ wd;
          mask_d  = wd;
          cnt_d   = (len_q == '0) ? PULSE_W'(1) : len_q;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        cnt_d = cnt_q - PULSE_W'(1);
        if (pulse_wr) overrun_d = 1'b1;
        if (restore) begin
          out_d   = out_wr ^ mask_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    case (address)
      3'd0:    readdata_d = 32'(out_q);
      3'd1:    readdata_d = 32'(len_q);
      3'd2:    readdata_d = {31'b0, irq_mask_q};
      3'd3:    readdata_d = {29'b0, overrun_q, done_q, (state_q == ACTIVE)};
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_q      <= RESET_VALUE;
      readdata_q <= '0;
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      mask_q     <= '0;
      irq_mask_q <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      out_q      <= out_d;
      readdata_q <= readdata_d;
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      irq_mask_q <= irq_mask_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign irq = done_q & irq_mask_q;

`else
  always_comb begin
    out_d = out_wr;
    case (address)
      3'd0:    readdata_d = 32'(out_q);
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_q      <= RESET_VALUE;
      readdata_q <= '0;
    end else begin
      out_q      <= out_d;
      readdata_q <= readdata_d;
    end
  end

  assign irq = 1'b0;
`endif

  assign out_port = out_q;
  assign readdata = readdata_q;

endmodule

`default_nettype wire

// File: tb/tb_nios_led_out.sv
// +--------------------------------------------------------------------------+
// | tb_nios_led_out : self-checking bench for nios_led_out                    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_nios_led_out;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [7:0]  out_port;

  int errors = 0;
  int checks = 0;

  nios_led_out #(
    .WIDTH      (8),
    .PULSE_W    (16),
    .RESET_VALUE(8'hA5)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .out_port  (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: register contents plus the absolute edge at which a running pulse ends.
  logic [7:0]  m_out;
  logic [7:0]  m_mask;
  logic [15:0] m_len;
  logic        m_im;
  logic        m_done;
  logic        m_ovr;
  logic        m_busy;
  int          m_end;
  logic [31:0] m_rd;
  int          edge_n = 0;

  function automatic logic m_irq();
`ifdef NIOS_LED_OUT_PULSE_EN
    return m_done & m_im;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step(input logic rn, input logic [2:0] a, input logic cs,
                      input logic wn, input logic [31:0] d);
    logic        w;
    logic [7:0]  wdat;
    logic [7:0]  o;
    logic [31:0] rd;
    int          e;
    reset_n    = rn;
    address    = a;
    chipselect = cs;
    write_n    = wn;
    writedata  = d;
    edge_n++;
    e    = edge_n;
    w    = cs && !wn;
    wdat = d[7:0];
    rd   = 32'h0;
    if (a == 3'd0) rd = {24'h0, m_out};
`ifdef NIOS_LED_OUT_PULSE_EN
    if (a == 3'd1) rd = {16'h0, m_len};
    if (a == 3'd2) rd = {31'h0, m_im};
    if (a == 3'd3) rd = {29'h0, m_ovr, m_done, m_busy};
`endif
    if (!rn) begin
      m_out = 8'hA5; m_mask = 8'h00; m_len = 16'h0; m_im = 1'b0;
      m_done = 1'b0; m_ovr = 1'b0; m_busy = 1'b0; m_end = 0; m_rd = 32'h0;
    end else begin
      m_rd = rd;
      o = m_out;
      if (w && a == 3'd0) o = wdat;
      if (w && a == 3'd4) o = m_out | wdat;
      if (w && a == 3'd5) o = m_out & ~wdat;
`ifdef NIOS_LED_OUT_PULSE_EN
      if (w && a == 3'd1) m_len = d[15:0];
      if (w && a == 3'd2) m_im = d[0];
      if (w && a == 3'd3) begin m_done = 1'b0; m_ovr = 1'b0; end
      if (m_busy) begin
        if (w && a == 3'd6) m_ovr = 1'b1;
        if (e == m_end) begin
          o = o ^ m_mask; m_done = 1'b1; m_busy = 1'b0;
        end
      end else if (w && a == 3'd6 && wdat != 8'h00) begin
        o = o ^ wdat; m_mask = wdat; m_busy = 1'b1;
        m_end = e + ((m_len == 16'h0) ? 1 : int'(m_len));
      end
`endif
      m_out = o;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 3'd0, 1'b1, 1'b0, 32'hFF);
    step(1'b0, 3'd0, 1'b1, 1'b1, 32'h0);
    checks++; if (out_port !== 8'hA5) begin errors++; $display("FAIL reset_out: got %h expected %h", out_port, 8'hA5); end
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h expected %h", readdata, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
  endtask

  task automatic test_set_clear();
    step(1'b1, 3'd0, 1'b1, 1'b0, 32'h0F);
    checks++; if (out_port !== 8'h0F) begin errors++; $display("FAIL data_write: got %h expected %h", out_port, 8'h0F); end
    checks++; if (readdata !== 32'hA5) begin errors++; $display("FAIL read_prewrite: got %h expected %h", readdata, 32'hA5); end
    step(1'b1, 3'd4, 1'b1, 1'b0, 32'h30);
    checks++; if (out_port !== 8'h3F) begin errors++; $display("FAIL outset: got %h expected %h", out_port, 8'h3F); end
    step(1'b1, 3'd5, 1'b1, 1'b0, 32'h03);
    checks++; if (out_port !== 8'h3C) begin errors++; $display("FAIL outclr: got %h expected %h", out_port, 8'h3C); end
    step(1'b1, 3'd0, 1'b1, 1'b1, 32'h0);
    checks++; if (readdata !== 32'h3C) begin errors++; $display("FAIL read_data: got %h expected %h", readdata, 32'h3C); end
    step(1'b1, 3'd0, 1'b0, 1'b0, 32'hFF);
    checks++; if (out_port !== 8'h3C) begin errors++; $display("FAIL no_cs_write: got %h expected %h", out_port, 8'h3C); end
  endtask

`ifdef NIOS_LED_OUT_PULSE_EN
  task automatic test_pulse_len();
    step(1'b1, 3'd1, 1'b1, 1'b0, 32'd4);
    step(1'b1, 3'd2, 1'b1, 1'b0, 32'd1);
    step(1'b1, 3'd0, 1'b1, 1'b0, 32'h00);
    step(1'b1, 3'd6, 1'b1, 1'b0, 32'h81);
    checks++; if (out_port !== 8'h81) begin errors++; $display("FAIL pulse_start: got %h expected %h", out_port, 8'h81); end
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 3'd3, 1'b1, 1'b1, 32'h0);
      checks++; if (out_port !== ((k < 4) ? 8'h81 : 8'h00)) begin errors++; $display("FAIL pulse_hold[%0d]: got %h expected %h", k, out_port, (k < 4) ? 8'h81 : 8'h00); end
      checks++; if (readdata !== 32'h1) begin errors++; $display("FAIL pulse_busy[%0d]: got %h expected %h", k, readdata, 32'h1); end
      checks++; if (irq !== (k == 4)) begin errors++; $display("FAIL pulse_irq[%0d]: got %b expected %b", k, irq, k == 4); end
    end
    step(1'b1, 3'd3, 1'b1, 1'b1, 32'h0);
    checks++; if (readdata !== 32'h2) begin errors++; $display("FAIL pulse_status_done: got %h expected %h", readdata, 32'h2); end
    step(1'b1, 3'd3, 1'b1, 1'b0, 32'h0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
  endtask

  task automatic test_zero_len_overrun();
    step(1'b1, 3'd1, 1'b1, 1'b0, 32'd0);
    step(1'b1, 3'd6, 1'b1, 1'b0, 32'h01);
    checks++; if (out_port !== 8'h01) begin errors++; $display("FAIL zero_len_on: got %h expected %h", out_port, 8'h01); end
    step(1'b1, 3'd7, 1'b1, 1'b1, 32'h0);
    checks++; if (out_port !== 8'h00) begin errors++; $display("FAIL zero_len_off: got %h expected %h", out_port, 8'h00); end
    step(1'b1, 3'd3, 1'b1, 1'b0, 32'h0);
    step(1'b1, 3'd1, 1'b1, 1'b0, 32'd10);
    step(1'b1, 3'd6, 1'b1, 1'b0, 32'h02);
    step(1'b1, 3'd7, 1'b1, 1'b1, 32'h0);
    step(1'b1, 3'd7, 1'b1, 1'b1, 32'h0);
    step(1'b1, 3'd6, 1'b1, 1'b0, 32'h04);
    checks++; if (out_port !== 8'h02) begin errors++; $display("FAIL overrun_ignored: got %h expected %h", out_port, 8'h02); end
    for (int k = 0; k < 6; k++) step(1'b1, 3'd7, 1'b1, 1'b1, 32'h0);
    checks++; if (out_port !== 8'h02) begin errors++; $display("FAIL long_pulse_hold: got %h expected %h", out_port, 8'h02); end
    step(1'b1, 3'd3, 1'b1, 1'b1, 32'h0);
    checks++; if (out_port !== 8'h00) begin errors++; $display("FAIL long_pulse_end: got %h expected %h", out_port, 8'h00); end
    checks++; if (readdata !== 32'h5) begin errors++; $display("FAIL overrun_busy: got %h expected %h", readdata, 32'h5); end
    step(1'b1, 3'd3, 1'b1, 1'b1, 32'h0);
    checks++; if (readdata !== 32'h6) begin errors++; $display("FAIL overrun_done: got %h expected %h", readdata, 32'h6); end
  endtask

  task automatic test_collision();
    step(1'b1, 3'd3, 1'b1, 1'b0, 32'h0);
    step(1'b1, 3'd1, 1'b1, 1'b0, 32'd3);
    step(1'b1, 3'd6, 1'b1, 1'b0, 32'h01);
    step(1'b1, 3'd7, 1'b1, 1'b1, 32'h0);
    step(1'b1, 3'd7, 1'b1, 1'b1, 32'h0);
    checks++; if (out_port !== 8'h01) begin errors++; $display("FAIL collide_pre: got %h expected %h", out_port, 8'h01); end
    step(1'b1, 3'd0, 1'b1, 1'b0, 32'hF0);
    checks++; if (out_port !== 8'hF1) begin errors++; $display("FAIL collide_data: got %h expected %h", out_port, 8'hF1); end
  endtask

  task automatic test_reset_mid_pulse();
    step(1'b1, 3'd3, 1'b1, 1'b0, 32'h0);
    step(1'b1, 3'd1, 1'b1, 1'b0, 32'd100);
    step(1'b1, 3'd6, 1'b1, 1'b0, 32'hFF);
    for (int k = 0; k < 5; k++) step(1'b1, 3'd7, 1'b1, 1'b1, 32'h0);
    step(1'b0, 3'd7, 1'b1, 1'b1, 32'h0);
    checks++; if (out_port !== 8'hA5) begin errors++; $display("FAIL midreset_out: got %h expected %h", out_port, 8'hA5); end
    step(1'b1, 3'd2, 1'b1, 1'b0, 32'd1);
    for (int k = 0; k < 110; k++) step(1'b1, 3'd3, 1'b1, 1'b1, 32'h0);
    checks++; if (out_port !== 8'hA5) begin errors++; $display("FAIL midreset_no_restore: got %h expected %h", out_port, 8'hA5); end
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL midreset_status: got %h expected %h", readdata, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq: got %b expected 0", irq); end
  endtask
`else
  task automatic test_disabled_regs();
    step(1'b1, 3'd0, 1'b1, 1'b0, 32'h5A);
    for (int k = 0; k < 4; k++) begin
      logic [2:0] a;
      a = (k == 0) ? 3'd1 : (k == 1) ? 3'd2 : (k == 2) ? 3'd3 : 3'd6;
      step(1'b1, a, 1'b1, 1'b0, 32'hFFFF_FFFF);
      checks++; if (out_port !== 8'h5A) begin errors++; $display("FAIL disabled_write[%0d]: got %h expected %h", a, out_port, 8'h5A); end
      step(1'b1, a, 1'b1, 1'b1, 32'h0);
      checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL disabled_read[%0d]: got %h expected %h", a, readdata, 32'h0); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL disabled_irq[%0d]: got %b expected 0", a, irq); end
    end
  endtask
`endif

  task automatic test_random();
    int bad = 0;
    step(1'b0, 3'd0, 1'b0, 1'b1, 32'h0);
    for (int k = 0; k < 600; k++) begin
      logic [2:0]  a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd1) d = $urandom_range(0, 8);
      step(($urandom_range(0, 99) != 0), a, ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), d);
      checks++;
      if (out_port !== m_out || readdata !== m_rd || irq !== m_irq()) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d]: got out=%h rd=%h irq=%b expected out=%h rd=%h irq=%b",
                   k, out_port, readdata, irq, m_out, m_rd, m_irq());
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    test_reset();
    test_set_clear();
`ifdef NIOS_LED_OUT_PULSE_EN
    test_pulse_len();
    test_zero_len_overrun();
    test_collision();
    test_reset_mid_pulse();
`else
    test_disabled_regs();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
